// File: rtl/breath_led_multi.sv
// Multi-channel breathing-LED PWM controller: one shared triangle-wave ramp
// drives CH_NUM pins, each in off / on / breath / blink mode.
module breath_led_multi #(
   parameter int unsigned CH_NUM     = 4,
   parameter int unsigned CNT_1US    = 49,
   parameter int unsigned STEPS      = 1000,
   parameter int unsigned STEP_W     = 10,
   parameter bit          ACTIVE_LOW = 1'b1,
   parameter bit          PHASE_ALT  = 1'b0
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  en,
   input  logic [2*CH_NUM-1:0]   mode,
   output logic [CH_NUM-1:0]     led_out,
   output logic                  ramp_end
);

   typedef enum logic [1:0] {
      MODE_OFF    = 2'b00,
      MODE_ON     = 2'b01,
      MODE_BREATH = 2'b10,
      MODE_BLINK  = 2'b11
   } mode_e;

   localparam int unsigned         US_W      = (CNT_1US > 0) ? $clog2(CNT_1US + 1) : 1;
   localparam logic [US_W-1:0]     US_LAST   = US_W'(CNT_1US);
   localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEPS - 1);

   logic [US_W-1:0]   cnt_us;
   logic [STEP_W-1:0] cnt_ms;
   logic [STEP_W-1:0] cnt_s;
   logic              dir;
   logic              tick_us;
   logic              frame_end;
   logic              rev;
   logic [CH_NUM-1:0] lit;
   logic [STEP_W-1:0] lvl;
   logic              dir_i;

   // Events are gated by en so a zero prescaler count cannot fire while held idle
   always_comb begin
      tick_us   = en && (cnt_us == US_LAST);
      frame_end = tick_us && (cnt_ms == STEP_LAST);
      rev       = frame_end && (cnt_s == STEP_LAST);
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst || !en) begin
         cnt_us <= '0;
         cnt_ms <= '0;
         cnt_s  <= '0;
         dir    <= 1'b0;
      end else begin
         cnt_us <= tick_us ? '0 : cnt_us + 1'b1;
         if (tick_us)
            cnt_ms <= frame_end ? '0 : cnt_ms + 1'b1;
         if (frame_end)
            cnt_s <= rev ? '0 : cnt_s + 1'b1;
         if (rev)
            dir <= ~dir;
      end
   end

   always_comb begin
      lit   = '0;
      lvl   = '0;
      dir_i = 1'b0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
         dir_i = dir ^ (PHASE_ALT && (i % 2 == 1));
         lvl   = dir_i ? (STEP_LAST - cnt_s) : cnt_s;
         case (mode_e'(mode[2*i +: 2]))
            MODE_OFF:    lit[i] = 1'b0;
            MODE_ON:     lit[i] = 1'b1;
            MODE_BREATH: lit[i] = en && (cnt_ms < lvl);
            MODE_BLINK:  lit[i] = en && !dir_i;
            default:     lit[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         led_out  <= {CH_NUM{ACTIVE_LOW}};
         ramp_end <= 1'b0;
      end else begin
         led_out  <= lit ^ {CH_NUM{ACTIVE_LOW}};
         ramp_end <= rev;
      end
   end

endmodule

// File: tb/tb_breath_led_multi.sv
// Self-checking bench for breath_led_multi: directed test-plan checks plus a
// randomized run against a time-index reference model.
module tb_breath_led_multi;

   localparam int unsigned CH    = 2;
   localparam int unsigned C1US  = 1;
   localparam int unsigned ST    = 4;
   localparam int unsigned SW    = 2;
   localparam bit          AL    = 1'b1;
   localparam bit          PA    = 1'b1;
   localparam int          TICK  = C1US + 1;
   localparam int          FRAME = TICK * ST;
   localparam int          RAMP  = FRAME * ST;

   logic              sys_clk = 1'b0;
   logic              sys_rst = 1'b1;
   logic              en      = 1'b1;
   logic [2*CH-1:0]   mode    = 4'b0101;
   logic [CH-1:0]     led_out;
   logic              ramp_end;

   int                n_cmp = 0;
   int                n_err = 0;
   int                t     = 0;
   logic [CH-1:0]     exp_led;
   logic              exp_re;

   always #5 sys_clk = ~sys_clk;

   breath_led_multi #(
      .CH_NUM    (CH),
      .CNT_1US   (C1US),
      .STEPS     (ST),
      .STEP_W    (SW),
      .ACTIVE_LOW(AL),
      .PHASE_ALT (PA)
   ) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .en      (en),
      .mode    (mode),
      .led_out (led_out),
      .ramp_end(ramp_end)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Brightness state derived from elapsed clocks since the last restart
   function automatic logic [CH-1:0] ref_lit(input int tt, input logic [2*CH-1:0] m, input logic e);
      int ms, s, d, dc, lvl;
      logic [1:0] md;
      logic [CH-1:0] r;
      ms = (tt / TICK) % ST;
      s  = (tt / FRAME) % ST;
      d  = (tt / RAMP) % 2;
      r  = '0;
      for (int ch = 0; ch < CH; ch++) begin
         dc  = d ^ ((PA && (ch % 2 == 1)) ? 1 : 0);
         lvl = (dc != 0) ? (ST - 1 - s) : s;
         md  = m[2*ch +: 2];
         case (md)
            2'b00: r[ch] = 1'b0;
            2'b01: r[ch] = 1'b1;
            2'b10: r[ch] = e && (ms < lvl);
            default: r[ch] = e && (dc == 0);
         endcase
      end
      return r;
   endfunction

   task automatic step();
      @(posedge sys_clk);
      if (sys_rst) begin
         exp_led = {CH{AL}};
         exp_re  = 1'b0;
         t       = 0;
      end else begin
         exp_led = ref_lit(t, mode, en) ^ {CH{AL}};
         exp_re  = en && (t % RAMP == RAMP - 1);
         t       = en ? (t + 1) % (2 * RAMP) : 0;
      end
      #1;
      check("led_out", 32'(led_out), 32'(exp_led));
      check("ramp_end", 32'(ramp_end), 32'(exp_re));
   endtask

   initial begin
      int exp0[8] = '{0, 2, 4, 6, 6, 4, 2, 0};
      int low0, low1, re_at, n;

      // reset with all channels on, then release
      sys_rst = 1'b1;
      step();
      step();
      check("rst_led", 32'(led_out), 32'h3);
      sys_rst = 1'b0;
      step();
      check("rel_led", 32'(led_out), 32'h0);

      // breath on both channels from a clean restart
      sys_rst = 1'b1;
      mode    = 4'b1010;
      step();
      sys_rst = 1'b0;
      re_at   = -1;
      for (int f = 0; f < 8; f++) begin
         low0 = 0;
         low1 = 0;
         for (int c = 0; c < FRAME; c++) begin
            step();
            low0 += (led_out[0] == 1'b0) ? 1 : 0;
            low1 += (led_out[1] == 1'b0) ? 1 : 0;
            if (ramp_end && re_at < 0) re_at = f * FRAME + c;
         end
         check("ch0_frame_low", 32'(low0), 32'(exp0[f]));
         check("ch_pair_sum", 32'(low0 + low1), 32'd6);
      end
      check("ramp_end_pos", 32'(re_at), 32'd31);

      // reset pulse at clock 45 of a breath cycle
      sys_rst = 1'b1;
      step();
      sys_rst = 1'b0;
      for (int k = 0; k < 44; k++) step();
      sys_rst = 1'b1;
      step();
      sys_rst = 1'b0;
      n = 0;
      do begin
         step();
         n++;
      end while (!ramp_end && n < 200);
      check("re_after_rst", 32'(n), 32'd32);

      // en drop mid-ramp forces breath unlit, then channel 1 off -> on
      for (int k = 0; k < 10; k++) step();
      en = 1'b0;
      step();
      check("en_off_led", 32'(led_out), 32'h3);
      mode = 4'b0110;
      step();
      check("on_latency", 32'(led_out), 32'h1);
      en = 1'b1;

      // randomized modes, enable toggles and occasional resets
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(15) == 0) mode = 4'($urandom);
         if ($urandom_range(63) == 0) en = ~en;
         sys_rst = ($urandom_range(299) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
